// File: rtl/tinyml_pkg.sv
// Shared types for the vector-buffer arbiter slice.
// Buffer id width, arbiter state encoding, tile element type.
package tinyml_pkg;

  localparam int BUF_ID_W = 5;
  localparam int ELEM_W   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef logic signed [ELEM_W-1:0] tile_elem_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_buffer_arbiter_if.sv
// Buffer-controller side of the arbiter.
// master = arbiter, slave = buffer controller.
interface vec_buffer_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_ELEMS = 32
);
  import tinyml_pkg::*;

  logic                                        vec_read_enable;
  logic [BUF_ID_W-1:0]                         vec_read_buffer_id;
  logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0] vec_read_tile;
  logic                                        vec_read_valid;
  logic                                        vec_write_enable;
  logic [BUF_ID_W-1:0]                         vec_write_buffer_id;
  logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0] vec_write_tile;

  modport master (
    output vec_read_enable,
    output vec_read_buffer_id,
    input  vec_read_tile,
    input  vec_read_valid,
    output vec_write_enable,
    output vec_write_buffer_id,
    output vec_write_tile
  );

  modport slave (
    input  vec_read_enable,
    input  vec_read_buffer_id,
    output vec_read_tile,
    output vec_read_valid,
    input  vec_write_enable,
    input  vec_write_buffer_id,
    input  vec_write_tile
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set req bit after last_i.
// Returns a one-hot pick and an any-request flag.
module rr_priority_picker
  import tinyml_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [idx_w(NUM_REQ)-1:0] last_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      any_o
);

  logic found;
  int   pos;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos = (int'(last_i) + i) % NUM_REQ;
      if (!found && req_i[pos]) begin
        gnt_o[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/vec_buffer_arbiter.sv
// Round-robin owner arbiter in front of the vector buffer controller.
// Optional grant watchdog enabled with `define ARB_TIMEOUT_EN.
module vec_buffer_arbiter
  import tinyml_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TILE_ELEMS     = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,

  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,

  input  logic [NUM_REQ-1:0]                rq_rd_en,
  input  logic [NUM_REQ-1:0][BUF_ID_W-1:0]  rq_rd_buf_id,
  output logic [NUM_REQ-1:0]                rq_rd_valid,
  output logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0] rq_rd_tile,

  input  logic [NUM_REQ-1:0]                rq_wr_en,
  input  logic [NUM_REQ-1:0][BUF_ID_W-1:0]  rq_wr_buf_id,
  input  logic signed [NUM_REQ-1:0][TILE_ELEMS-1:0][DATA_WIDTH-1:0] rq_wr_tile,

  vec_buffer_arbiter_if.master bus,

  output logic                      timeout_err,
  output logic [idx_w(NUM_REQ)-1:0] timeout_id
);

  localparam int IW = idx_w(NUM_REQ);
  typedef logic [IW-1:0] idx_t;

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  idx_t               owner_q, owner_d;
  idx_t               last_q, last_d;
  logic               rd_out_q, rd_out_d;

  logic [NUM_REQ-1:0] req_elig;
  logic [NUM_REQ-1:0] pick;
  logic               pick_any;
  idx_t               pick_idx;
  logic               own_req;
  logic               to_fire;

  assign own_req = req[owner_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               to_err_q, to_err_d;
  idx_t               to_id_q, to_id_d;
  logic [NUM_REQ-1:0] blk_q, blk_d;

  assign to_fire = (state_q == GRANT) && own_req &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // a timed-out owner stays out until it drops req once
  always_comb begin
    cnt_d    = (state_q == GRANT) ? cnt_q + 1'b1 : '0;
    to_err_d = to_fire;
    to_id_d  = to_fire ? owner_q : to_id_q;
    blk_d    = blk_q & req;
    if (to_fire) blk_d[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      to_err_q <= 1'b0;
      to_id_q  <= '0;
      blk_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      to_err_q <= to_err_d;
      to_id_q  <= to_id_d;
      blk_q    <= blk_d;
    end
  end

  assign req_elig    = req & ~blk_q;
  assign timeout_err = to_err_q;
  assign timeout_id  = to_id_q;
`else
  assign to_fire     = 1'b0;
  assign req_elig    = req;
  assign timeout_err = 1'b0;
  assign timeout_id  = '0;
`endif

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i  (req_elig),
    .last_i (last_q),
    .gnt_o  (pick),
    .any_o  (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = idx_t'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick;
          owner_d = pick_idx;
          last_d  = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!own_req || to_fire) begin
          gnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!rd_out_q) state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // buffer side follows the owner only while granted
  always_comb begin
    bus.vec_read_enable     = 1'b0;
    bus.vec_read_buffer_id  = '0;
    bus.vec_write_enable    = 1'b0;
    bus.vec_write_buffer_id = '0;
    bus.vec_write_tile      = '0;
    rq_rd_valid             = '0;
    if (state_q == GRANT) begin
      bus.vec_read_enable     = rq_rd_en[owner_q];
      bus.vec_read_buffer_id  = rq_rd_buf_id[owner_q];
      bus.vec_write_enable    = rq_wr_en[owner_q];
      bus.vec_write_buffer_id = rq_wr_buf_id[owner_q];
      bus.vec_write_tile      = rq_wr_tile[owner_q];
      rq_rd_valid = gnt_q & {NUM_REQ{bus.vec_read_valid}};
    end
  end

  assign rq_rd_tile = bus.vec_read_tile;

  always_comb begin
    rd_out_d = rd_out_q;
    if (bus.vec_read_enable)     rd_out_d = 1'b1;
    else if (bus.vec_read_valid) rd_out_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      last_q   <= idx_t'(NUM_REQ - 1);
      rd_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign gnt = gnt_q;

endmodule

// File: tb/tb_vec_buffer_arbiter.sv
// Directed + randomized bench for vec_buffer_arbiter.
// Timeout scenario builds only with ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_vec_buffer_arbiter;
  import tinyml_pkg::*;

  localparam int DW = 8;
  localparam int TE = 32;
  localparam int NR = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  typedef logic [TE*DW-1:0] tile_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0] req, gnt, rq_rd_en, rq_rd_valid, rq_wr_en;
  logic [NR-1:0][BUF_ID_W-1:0] rq_rd_buf_id, rq_wr_buf_id;
  logic signed [TE-1:0][DW-1:0] rq_rd_tile;
  logic signed [NR-1:0][TE-1:0][DW-1:0] rq_wr_tile;
  logic timeout_err;
  logic [1:0] timeout_id;

  vec_buffer_arbiter_if #(.DATA_WIDTH(DW), .TILE_ELEMS(TE)) bus ();

  vec_buffer_arbiter #(
    .DATA_WIDTH(DW), .TILE_ELEMS(TE),
    .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .gnt(gnt),
    .rq_rd_en(rq_rd_en), .rq_rd_buf_id(rq_rd_buf_id),
    .rq_rd_valid(rq_rd_valid), .rq_rd_tile(rq_rd_tile),
    .rq_wr_en(rq_wr_en), .rq_wr_buf_id(rq_wr_buf_id),
    .rq_wr_tile(rq_wr_tile), .bus(bus),
    .timeout_err(timeout_err), .timeout_id(timeout_id)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_next(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++)
      if (r[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NR-1:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int i = 0; i < TE * DW / 32; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  task automatic wait_gnt(input int maxc, output int who);
    who = -1;
    for (int c = 0; c < maxc && who < 0; c++) begin
      step();
      if (gnt != '0) who = oh_idx(gnt);
    end
    if (who < 0) chk("wait_gnt", {255'd0, |gnt}, 256'd1);
  endtask

  task automatic quiet();
    req = '0; rq_rd_en = '0; rq_wr_en = '0;
    rq_rd_buf_id = '0; rq_wr_buf_id = '0; rq_wr_tile = '0;
    bus.vec_read_valid = 1'b0; bus.vec_read_tile = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int who, exp_o, last_m, owner, hold, cnt;
  logic [NR-1:0] req_prev;
  logic rd_pend;
  tile_t t0, rd_tile_m;

  initial begin
    quiet();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rden", bus.vec_read_enable, 0);
    chk("rst_wren", bus.vec_write_enable, 0);
    chk("rst_toerr", timeout_err, 0);
    chk("rst_rdv", rq_rd_valid, 0);
    @(negedge clk) rst_n = 1'b1;

    // single requester, read path
    step(); req = 4'b0010; #1;
    chk("t1_pre", gnt, 0);
    step();
    chk("t1_gnt", gnt, 4'b0010);
    rq_rd_en = 4'b0011;
    rq_rd_buf_id[1] = 5'd3; rq_rd_buf_id[0] = 5'd9; #1;
    chk("t1_rden", bus.vec_read_enable, 1);
    chk("t1_rdid", bus.vec_read_buffer_id, 3);
    step(); rq_rd_en = '0;
    t0 = rand_tile();
    bus.vec_read_tile = t0; bus.vec_read_valid = 1'b1; #1;
    chk("t1_rdv", rq_rd_valid, 4'b0010);
    chk("t1_tile", rq_rd_tile, t0);
    step(); bus.vec_read_valid = 1'b0; req = '0;
    step();
    chk("t1_rel", gnt, 0);
    step(); step();

    // idle outputs stay zero
    rq_wr_buf_id = '1; rq_rd_buf_id = '1;
    rq_wr_tile = {rand_tile(), rand_tile(), rand_tile(), rand_tile()};
    rq_wr_en = 4'b1111; #1;
    chk("idle_rdid", bus.vec_read_buffer_id, 0);
    chk("idle_wrid", bus.vec_write_buffer_id, 0);
    chk("idle_wrtile", bus.vec_write_tile, 0);
    chk("idle_wren", bus.vec_write_enable, 0);

    // non-owner write is ignored
    rq_wr_en = '0; req = 4'b0001;
    step();
    chk("t3_gnt", gnt, 4'b0001);
    rq_wr_buf_id[0] = 5'd2; rq_wr_buf_id[1] = 5'd7;
    rq_wr_en = 4'b0010; #1;
    chk("t3_nowr", bus.vec_write_enable, 0);
    chk("t3_wrid", bus.vec_write_buffer_id, 2);
    step();
    rq_wr_en = 4'b0001; rq_rd_en = 4'b0001;
    rq_rd_buf_id[0] = 5'd4; rq_wr_buf_id[0] = 5'd6;
    t0 = rand_tile(); rq_wr_tile[0] = t0; #1;
    chk("both_rd", bus.vec_read_enable, 1);
    chk("both_wr", bus.vec_write_enable, 1);
    chk("both_rdid", bus.vec_read_buffer_id, 4);
    chk("both_wrid", bus.vec_write_buffer_id, 6);
    chk("both_tile", bus.vec_write_tile, t0);
    step();
    rq_rd_en = '0; rq_wr_en = '0;
    bus.vec_read_valid = 1'b1; req = '0;
    step(); bus.vec_read_valid = 1'b0;
    chk("t3_rel", gnt, 0);
    step(); step();

    // reset mid-grant
    req = 4'b0100;
    step();
    chk("t6_gnt", gnt, 4'b0100);
    rq_rd_en = 4'b0100; rq_wr_en = 4'b0100; #1;
    chk("t6_en", bus.vec_read_enable, 1);
    #2 rst_n = 1'b0; #1;
    chk("t6_gnt0", gnt, 0);
    chk("t6_en0", {bus.vec_read_enable, bus.vec_write_enable}, 0);
    quiet();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // round robin with all requesting
    last_m = NR - 1;
    step(); req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_o = rr_next(req, last_m);
      wait_gnt(8, who);
      chk($sformatf("rr%0d", k), gnt, 4'b1 << exp_o);
      last_m = exp_o;
      req[exp_o] = 1'b0;
      step();
      chk($sformatf("rr%0d_drop", k), gnt, 0);
      if (k < 4) req[exp_o] = 1'b1;
    end
    req = '0;
    step(); step();

    // release waits for outstanding read
    req = 4'b0100;
    wait_gnt(6, who);
    chk("t4_gnt", gnt, 4'b0100);
    rq_rd_en = 4'b0100; req = 4'b1100;
    step(); rq_rd_en = '0; req = 4'b1000;
    step();
    chk("t4_rel", gnt, 0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("t4_hold%0d", j), gnt, 0);
    end
    bus.vec_read_valid = 1'b1; #1;
    chk("t4_rdv0", rq_rd_valid, 0);
    step(); bus.vec_read_valid = 1'b0;
    chk("t4_hold_v", gnt, 0);
    exp_o = rr_next(req, 2);
    wait_gnt(4, who);
    chk("t4_next", gnt, 4'b1 << exp_o);
    req = '0;
    step(); step(); step();

`ifdef ARB_TIMEOUT_EN
    req = 4'b1000;
    wait_gnt(6, who);
    chk("to_gnt", gnt, 4'b1000);
    req = 4'b1001;
    cnt = 0;
    for (int c = 0; c < 40 && !timeout_err; c++) begin
      step();
      cnt++;
    end
    chk("to_cycle", cnt, TO);
    chk("to_id", timeout_id, 3);
    chk("to_gnt0", gnt, 0);
    step();
    chk("to_pulse", timeout_err, 0);
    wait_gnt(6, who);
    chk("to_next", gnt, 4'b0001);
    req = 4'b1000;
    repeat (6) step();
    chk("to_blk", gnt, 0);
    req = '0; step();
    req = 4'b1000;
    wait_gnt(6, who);
    chk("to_regrant", gnt, 4'b1000);
    req = '0;
    step(); step();
`endif

    // randomized phase
    rst_n = 1'b0; quiet();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    last_m = NR - 1; owner = -1; hold = 0;
    req_prev = '0; rd_pend = 1'b0; rd_tile_m = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      if (owner >= 0) begin
        if (!req_prev[owner]) begin
          chk("r_rel", gnt, 0);
          owner = -1;
        end else begin
          chk("r_hold", gnt, 4'b1 << owner);
        end
      end else if (gnt != '0) begin
        exp_o = rr_next(req_prev, last_m);
        chk("r_pick", gnt, 4'b1 << exp_o);
        owner = exp_o; last_m = exp_o; hold = 0;
      end
      bus.vec_read_valid = rd_pend;
      rd_tile_m = rand_tile();
      bus.vec_read_tile = rd_tile_m;
      for (int i = 0; i < NR; i++) begin
        if (i == owner) begin
          hold++;
          if (hold >= 10 || $urandom_range(0, 3) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
        end
      end
      rq_rd_en = 4'($urandom);
      rq_wr_en = 4'($urandom);
      for (int i = 0; i < NR; i++) begin
        rq_rd_buf_id[i] = 5'($urandom);
        rq_wr_buf_id[i] = 5'($urandom);
        rq_wr_tile[i] = rand_tile();
      end
      #1;
      if (owner >= 0) begin
        chk("r_rden", bus.vec_read_enable, rq_rd_en[owner]);
        chk("r_wren", bus.vec_write_enable, rq_wr_en[owner]);
        chk("r_rdid", bus.vec_read_buffer_id, rq_rd_buf_id[owner]);
        chk("r_wrid", bus.vec_write_buffer_id, rq_wr_buf_id[owner]);
        chk("r_wrtile", bus.vec_write_tile, rq_wr_tile[owner]);
        chk("r_rdv", rq_rd_valid,
            bus.vec_read_valid ? (4'b1 << owner) : 4'b0);
      end else begin
        chk("r_idle_en", {bus.vec_read_enable, bus.vec_write_enable}, 0);
        chk("r_idle_id", {bus.vec_read_buffer_id, bus.vec_write_buffer_id}, 0);
        chk("r_idle_tile", bus.vec_write_tile, 0);
        chk("r_idle_rdv", rq_rd_valid, 0);
      end
      chk("r_tile", rq_rd_tile, rd_tile_m);
      chk("r_toerr", timeout_err, 0);
      rd_pend = (owner >= 0) ? rq_rd_en[owner] : 1'b0;
      req_prev = req;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vec_buffer_arbiter.md
VEC_BUFFER_ARBITER -- requirements
Module: vec_buffer_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: element width in bits.
REQ-002 SHALL have parameter TILE_ELEMS, default 32: elements per vector tile.
REQ-003 SHALL have parameter NUM_REQ, default 4: number of execution-unit requesters.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096: grant watchdog limit, used only when ARB_TIMEOUT_EN is defined.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req, input, NUM_REQ: per-requester ownership request, held for the whole transaction.
REQ-008 SHALL have port gnt, output, NUM_REQ: one-hot ownership grant, registered.
REQ-009 SHALL have port rq_rd_en, input, NUM_REQ: per-requester single-cycle read pulse.
REQ-010 SHALL have port rq_rd_buf_id, input, NUM_REQ x 5: per-requester source buffer id.
REQ-011 SHALL have port rq_rd_valid, output, NUM_REQ: read-valid routed to the owner only.
REQ-012 SHALL have port rq_rd_tile, output, TILE_ELEMS x DATA_WIDTH signed: read tile broadcast to all requesters.
REQ-013 SHALL have port rq_wr_en, input, NUM_REQ: per-requester write pulse.
REQ-014 SHALL have port rq_wr_buf_id, input, NUM_REQ x 5: per-requester destination buffer id.
REQ-015 SHALL have port rq_wr_tile, input, NUM_REQ x TILE_ELEMS x DATA_WIDTH signed: per-requester write tile.
REQ-016 SHALL have ports vec_read_enable (out, 1), vec_read_buffer_id (out, 5), vec_read_tile (in, tile), vec_read_valid (in, 1): buffer controller read side.
REQ-017 SHALL have ports vec_write_enable (out, 1), vec_write_buffer_id (out, 5), vec_write_tile (out, tile): buffer controller write side.
REQ-018 SHALL have port timeout_err, output, 1, and timeout_id, output, $clog2(NUM_REQ): watchdog event pulse and offending requester.

Function
REQ-019 SHALL implement FSM states IDLE, GRANT and RELEASE.
REQ-020 In IDLE, with any req bit set, the arbiter SHALL register a one-hot gnt on the next edge, pick round-robin starting at (last_owner+1) mod NUM_REQ, and enter GRANT; this is 1-cycle grant latency.
REQ-021 In GRANT, buffer-side outputs SHALL be combinational muxes of the owner's rq_* signals; non-owner rd_en and wr_en SHALL be ignored.
REQ-022 rq_rd_valid SHALL equal vec_read_valid on the owner's bit only, and 0 on all other bits.
REQ-023 GRANT SHALL exit to RELEASE when the owner's req deasserts; gnt SHALL clear on that same edge.
REQ-024 A read-outstanding flag SHALL set on vec_read_enable and clear on vec_read_valid; if both occur in the same cycle, the flag stays set.
REQ-025 RELEASE SHALL drive all buffer-side enables to 0, discard any vec_read_valid, hold until the outstanding flag is clear, then enter IDLE.
REQ-026 Requests arriving during GRANT or RELEASE SHALL wait; no requester SHALL be starved beyond NUM_REQ-1 intervening grants.
REQ-027 rq_rd_en and rq_wr_en asserted by the owner in the same cycle SHALL both pass through unchanged.
REQ-028 While idle, vec_read_buffer_id, vec_write_buffer_id and vec_write_tile SHALL drive 0.

Reset
REQ-029 On rst_n low, the arbiter SHALL immediately set state to IDLE, and clear gnt, the outstanding flag, last_owner (to NUM_REQ-1), timeout_err and timeout_id, all enables and ids to 0.
REQ-030 Reset asserted mid-GRANT SHALL abort the transaction with no further buffer access; the first grant after reset SHALL go to the lowest-index requester.

Configuration
REQ-031 With ARB_TIMEOUT_EN defined, a counter SHALL run in GRANT; on reaching TIMEOUT_CYCLES, the arbiter SHALL force RELEASE, pulse timeout_err for 1 cycle, and capture the owner in timeout_id.
REQ-032 When ARB_TIMEOUT_EN forces a release, the arbiter SHALL ignore that requester's req until it deasserts.
REQ-033 Without ARB_TIMEOUT_EN, no counter SHALL exist, and timeout_err and timeout_id SHALL be tied 0.

Structure
REQ-034 Shared package tinyml_pkg SHALL hold BUF_ID_W=5, the arb_state_t typedef, and the tile element typedef.
REQ-035 Round-robin selection SHALL live in sub-module rr_priority_picker (req, last_owner -> one-hot, any).

Verification
REQ-036 Bench SHALL cover: reset release, then req=0b0010 -> gnt=0b0010 one cycle later; owner vec_read_enable with buf_id 3 passes to controller.
REQ-037 Bench SHALL cover: req=0b1111 held -> grants in order 0,1,2,3,0 as each owner drops req, with RELEASE one cycle between grants.
REQ-038 Bench SHALL cover: owner 2 drops req with read pending, vec_read_valid arrives 3 cycles later -> stays in RELEASE, rq_rd_valid all 0, IDLE after valid.
REQ-039 Bench SHALL cover: non-owner 1 pulses rq_wr_en with buf_id 7 during owner 0's grant -> vec_write_enable stays 0.
REQ-040 Bench SHALL cover: ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, owner 3 holds req -> timeout_err pulse at cycle 16, timeout_id=3, and the next waiting requester is granted.
REQ-041 Bench SHALL cover: rst_n low mid-GRANT -> gnt=0 and enables=0 within the same cycle; after release, req=0b1000 -> gnt=0b1000.
